// File: rtl/tff_pkg.sv
// Shared constants and types for the T flip-flop counter slice.
// Used by tff_cell and tff_sync_counter.
package tff_pkg;

    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam int   TFF_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_TOGGLE,
        SEL_LOAD,
        SEL_RESET
    } sel_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop bit with synchronous reset and parallel load.
// Priority per edge: rst > ld > t > hold; qb is its own register.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else if (ld) begin
            q  <= d;
            qb <= ~d;
        end else if (t) begin
            q  <= ~q;
            qb <= ~qb;
        end
    end

endmodule

// File: rtl/tff_sync_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter built from a chain of tff_cell bits.
// Define TFF_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module tff_sync_counter
    import tff_pkg::*;
#(
    parameter int WIDTH     = TFF_CNT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic             at_top;
    logic             at_bot;
    logic             bound;
    logic             do_rst;
    logic             do_ld;
    logic             do_bnd;
    logic             do_tgl;
    logic             wrap_next;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] t_chain;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] d;
    sel_e             sel;

    assign at_top = (q == MAX_Q);
    assign at_bot = (q == '0);
    assign bound  = (up == DIR_UP) ? at_top : at_bot;
    assign tc     = en & bound;
    assign load_q = (load_val > MAX_Q) ? MAX_Q : load_val;

    // Ripple-free T chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
    assign t_chain[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign t_chain[i] = (up == DIR_UP) ? &q[i-1:0] : ~|q[i-1:0];
    end

    assign do_rst = rst;
    assign do_ld  = ~rst & load;
    assign do_bnd = ~rst & ~load & tc;
    assign do_tgl = ~rst & ~load & en & ~bound;

    always_comb begin
        sel = SEL_HOLD;
        unique case (1'b1)
            do_rst: sel = SEL_RESET;
            do_ld:  sel = SEL_LOAD;
`ifdef TFF_COUNTER_SATURATE_EN
            do_bnd: sel = SEL_HOLD;
`else
            do_bnd: sel = SEL_LOAD;
`endif
            do_tgl: sel = SEL_TOGGLE;
            default: sel = SEL_HOLD;
        endcase
    end

    // Boundary steps go through the load path so non-power-of-two moduli wrap correctly.
    always_comb begin
        t  = '0;
        ld = '0;
        d  = '0;
        unique case (sel)
            SEL_TOGGLE: t = t_chain;
            SEL_LOAD: begin
                ld = '1;
                if (load) begin
                    d = load_q;
                end else if (up == DIR_UP) begin
                    d = '0;
                end else begin
                    d = MAX_Q;
                end
            end
            SEL_RESET: begin
                t  = '0;
                ld = '0;
            end
            default: begin
                t  = '0;
                ld = '0;
            end
        endcase
    end

`ifdef TFF_COUNTER_SATURATE_EN
    assign wrap_next = 1'b0;
`else
    assign wrap_next = do_bnd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .ld  (ld[i]),
            .d   (d[i]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

endmodule
